pwm_duty_ramp_ctrl: RTL and testbench

Controller that sequences the duty-cycle input (dc, 0..100 %) of the team's PWM generator. It accepts a target duty through a valid/ready handshake. It then ramps dc toward that target in fixed steps, changing it only on PWM period boundaries so no period is truncated. An emergency-stop input forces dc to 0 immediately.

---
 rtl/pwm_duty_ramp_ctrl.sv | 115 +++++++++++
 tb/tb_pwm_duty_ramp_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp_ctrl.sv
// Ramps the PWM duty toward an accepted target in bounded steps, only on period boundaries.
// Latency: first dc change at the PERIODS_PER_STEP-th period_end after acceptance.
// Backpressure: tgt_ready low while ramping, halted or in reset; requests are never queued.
module pwm_duty_ramp_ctrl #(
   parameter int DC_W             = 7,
   parameter int DC_MAX           = 100,
   parameter int STEP             = 10,
   parameter int PERIODS_PER_STEP = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tgt_valid,
   input  logic [DC_W-1:0] tgt_dc,
   output logic            tgt_ready,
   input  logic            period_end,
   input  logic            estop,
   output logic [DC_W-1:0] dc,
   output logic            busy,
   output logic            done,
   output logic            clamp
);

   localparam int CNT_W = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
   localparam logic [DC_W:0]    MAX_E    = (DC_W+1)'(DC_MAX);
   localparam logic [DC_W:0]    STEP_E   = (DC_W+1)'(STEP);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(PERIODS_PER_STEP - 1);

   typedef enum logic [1:0] {IDLE, RAMP, HALT} state_t;

   state_t           state, state_n;
   logic [DC_W-1:0]  target, target_n, dc_n;
   logic [CNT_W-1:0] div_cnt, div_n;
   logic             done_n, clamp_n;

   logic [DC_W:0]    dc_e, tgt_e, req_e, diff, step_amt, dc_step;
   logic             over_max;
   logic [DC_W-1:0]  req_clamped;

   assign tgt_ready = (state == IDLE) && !estop && !reset;
   assign busy      = (state == RAMP);

   // One step toward target, computed one bit wider so the subtraction cannot wrap.
   always_comb begin
      dc_e        = {1'b0, dc};
      tgt_e       = {1'b0, target};
      req_e       = {1'b0, tgt_dc};
      over_max    = (req_e > MAX_E);
      req_clamped = over_max ? MAX_E[DC_W-1:0] : tgt_dc;
      diff        = (tgt_e > dc_e) ? (tgt_e - dc_e) : (dc_e - tgt_e);
      step_amt    = (diff < STEP_E) ? diff : STEP_E;
      dc_step     = (tgt_e > dc_e) ? (dc_e + step_amt) : (dc_e - step_amt);
   end

   always_comb begin
      state_n  = state;
      dc_n     = dc;
      target_n = target;
      div_n    = div_cnt;
      done_n   = 1'b0;
      clamp_n  = 1'b0;
      if (estop) begin
         state_n  = HALT;
         dc_n     = '0;
         target_n = '0;
         div_n    = '0;
      end else begin
         case (state)
            IDLE: begin
               if (tgt_valid) begin
                  target_n = req_clamped;
                  clamp_n  = over_max;
                  div_n    = '0;
                  if (req_clamped == dc) done_n = 1'b1;
                  else                   state_n = RAMP;
               end
            end
            RAMP: begin
               if (period_end) begin
                  if (div_cnt == DIV_LAST) begin
                     div_n = '0;
                     dc_n  = dc_step[DC_W-1:0];
                     if (dc_step == tgt_e) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                     end
                  end else begin
                     div_n = div_cnt + CNT_W'(1);
                  end
               end
            end
            HALT:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         dc      <= '0;
         target  <= '0;
         div_cnt <= '0;
         done    <= 1'b0;
         clamp   <= 1'b0;
      end else begin
         state   <= state_n;
         dc      <= dc_n;
         target  <= target_n;
         div_cnt <= div_n;
         done    <= done_n;
         clamp   <= clamp_n;
      end
   end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl with STEP=10, PERIODS_PER_STEP=2.
module tb_pwm_duty_ramp_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       tgt_valid;
   logic [6:0] tgt_dc;
   logic       tgt_ready;
   logic       period_end;
   logic       estop;
   logic [6:0] dc;
   logic       busy;
   logic       done;
   logic       clamp;

   int checks = 0;
   int errors = 0;

   pwm_duty_ramp_ctrl #(
      .DC_W(7), .DC_MAX(100), .STEP(10), .PERIODS_PER_STEP(2)
   ) dut (
      .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_dc(tgt_dc),
      .tgt_ready(tgt_ready), .period_end(period_end), .estop(estop),
      .dc(dc), .busy(busy), .done(done), .clamp(clamp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gap();
      repeat (255) tick();
   endtask

   task automatic pe();
      period_end = 1'b1;
      tick();
      period_end = 1'b0;
   endtask

   // Present a target for exactly one edge; with_pe also pulses period_end on that edge.
   task automatic accept(input int v, input bit with_pe);
      chk("ready_before_accept", tgt_ready, 1);
      tgt_valid  = 1'b1;
      tgt_dc     = 7'(v);
      period_end = with_pe;
      tick();
      tgt_valid  = 1'b0;
      period_end = 1'b0;
   endtask

   // Expected dc moves by at most 10 toward tgt on every second pulse.
   task automatic run_ramp(input int start, input int tgt, input int pulses);
      int exp_dc;
      exp_dc = start;
      for (int i = 1; i <= pulses; i++) begin
         pe();
         if (i % 2 == 0) begin
            if (tgt > exp_dc) exp_dc = (tgt - exp_dc < 10) ? tgt : exp_dc + 10;
            else              exp_dc = (exp_dc - tgt < 10) ? tgt : exp_dc - 10;
         end
         chk("ramp_dc", dc, exp_dc);
         chk("ramp_done", done, (i % 2 == 0) && (exp_dc == tgt));
         chk("ramp_busy", busy, exp_dc != tgt);
         if (exp_dc == tgt) tgt_valid = 1'b0;
         gap();
      end
   endtask

   initial begin
      reset      = 1'b1;
      tgt_valid  = 1'b0;
      tgt_dc     = '0;
      period_end = 1'b0;
      estop      = 1'b0;

      // 1. reset
      repeat (3) tick();
      chk("rst_ready", tgt_ready, 0);
      chk("rst_dc", dc, 0);
      reset = 1'b0;
      #1;
      chk("rel_ready", tgt_ready, 1);
      chk("rel_busy", busy, 0);
      chk("rel_done", done, 0);
      chk("rel_clamp", clamp, 0);

      // 2. 0 -> 35, with a competing request held through the ramp
      accept(35, 1'b0);
      chk("t2_busy", busy, 1);
      chk("t2_clamp", clamp, 0);
      chk("t2_done", done, 0);
      chk("t2_dc", dc, 0);
      tgt_valid = 1'b1;
      tgt_dc    = 7'd50;
      chk("t2_ready_ramp", tgt_ready, 0);
      run_ramp(0, 35, 8);
      tick();
      chk("t2_done_once", done, 0);
      chk("t2_no_queue", dc, 35);
      chk("t2_idle_busy", busy, 0);

      // 3. clamp to 100, then back to 0
      accept(120, 1'b0);
      chk("t3_clamp", clamp, 1);
      chk("t3_busy", busy, 1);
      tick();
      chk("t3_clamp_once", clamp, 0);
      run_ramp(35, 100, 14);
      tick();
      accept(0, 1'b0);
      chk("t3b_clamp", clamp, 0);
      run_ramp(100, 0, 20);
      tick();

      // 4. target equal to current dc
      accept(20, 1'b0);
      run_ramp(0, 20, 4);
      tick();
      accept(20, 1'b0);
      chk("t4_done", done, 1);
      chk("t4_busy", busy, 0);
      chk("t4_dc", dc, 20);
      tick();
      chk("t4_done_once", done, 0);
      chk("t4_dc_hold", dc, 20);

      // 5. estop mid-ramp
      accept(80, 1'b0);
      run_ramp(20, 80, 4);
      chk("t5_pre_dc", dc, 40);
      estop      = 1'b1;
      period_end = 1'b1;
      tgt_valid  = 1'b1;
      tgt_dc     = 7'd60;
      #1;
      chk("t5_ready_estop", tgt_ready, 0);
      tick();
      period_end = 1'b0;
      tgt_valid  = 1'b0;
      chk("t5_dc", dc, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_ready", tgt_ready, 0);
      tick();
      chk("t5_hold_dc", dc, 0);
      chk("t5_hold_ready", tgt_ready, 0);
      estop = 1'b0;
      tick();
      chk("t5_rel_ready", tgt_ready, 1);
      chk("t5_rel_dc", dc, 0);
      chk("t5_rel_done", done, 0);

      // 6. reset mid-ramp coincident with period_end
      accept(90, 1'b0);
      run_ramp(0, 90, 10);
      chk("t6_pre_dc", dc, 50);
      reset      = 1'b1;
      period_end = 1'b1;
      tick();
      period_end = 1'b0;
      chk("t6_dc", dc, 0);
      chk("t6_busy", busy, 0);
      chk("t6_ready_rst", tgt_ready, 0);
      reset = 1'b0;
      #1;
      chk("t6_ready_rel", tgt_ready, 1);
      accept(10, 1'b1);
      chk("t6_acc_dc", dc, 0);
      chk("t6_acc_busy", busy, 1);
      gap();
      pe();
      chk("t6_pe1_dc", dc, 0);
      chk("t6_pe1_done", done, 0);
      gap();
      pe();
      chk("t6_pe2_dc", dc, 10);
      chk("t6_pe2_done", done, 1);
      chk("t6_pe2_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
